// File: rtl/mem_system.sv
// mem_system: direct-mapped write-back cache (32 lines x 4 words) over a 32K x 16 main memory; define MEM_SYSTEM_DUMP_EN to enable the createdump file dump
module mem_system (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit
);
  typedef enum logic [2:0] {IDLE, WB, FILL, WAIT, INSTALL, DONE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:1] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        wr_q, wr_d;
  logic [31:0] valid_q, valid_d, dirty_q, dirty_d;
  logic [47:0] buf_q, buf_d;
  logic [15:0] dout_q, dout_d;
  logic        done_q, done_d, stall_q, stall_d, hit_q, hit_d;
  logic [7:0]  tag_mem [32];
  logic [63:0] line_mem [32];
  logic [15:0] main_mem [32768];
  logic [14:0] rd_addr_q;
  logic [15:0] rd_data_q;
  logic [4:0]  idx;
  logic [7:0]  req_tag, cur_tag;
  logic [1:0]  wsel;
  logic [63:0] cur_line, fill_line, lw_line;
  logic        hit_in, lw_en, unused_bits;

  assign idx       = state_q == IDLE ? Addr[7:3] : addr_q[7:3];
  assign req_tag   = state_q == IDLE ? Addr[15:8] : addr_q[15:8];
  assign wsel      = state_q == IDLE ? Addr[2:1] : addr_q[2:1];
  assign cur_line  = line_mem[idx];
  assign cur_tag   = tag_mem[idx];
  assign hit_in    = valid_q[idx] && cur_tag == req_tag;
  assign fill_line = {rd_data_q, buf_q};
  assign DataOut   = dout_q;
  assign Done      = done_q;
  assign Stall     = stall_q;
  assign CacheHit  = hit_q;

  // next state: hit/miss decision, fill sequencing and the line image to write back into the cache
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 2'd1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    buf_d   = {rd_data_q, buf_q[47:16]};
    dout_d  = 16'h0;
    hit_d   = 1'b0;
    lw_en   = 1'b0;
    lw_line = state_q == IDLE ? cur_line : fill_line;
    lw_line[{wsel, 4'b0} +: 16] = state_q == IDLE ? DataIn : wdata_q;
    if (state_q == IDLE && (Rd || Wr)) begin
      addr_d  = Addr[15:1];
      wdata_d = DataIn;
      wr_d    = Wr;
      cnt_d   = 2'd0;
      if (hit_in) begin
        state_d      = DONE;
        hit_d        = 1'b1;
        lw_en        = Wr;
        dirty_d[idx] = dirty_q[idx] | Wr;
        dout_d       = Wr ? 16'h0 : cur_line[{wsel, 4'b0} +: 16];
      end else
        state_d = valid_q[idx] && dirty_q[idx] ? WB : FILL;
    end else if (state_q == WB || state_q == FILL) begin
      if (cnt_q == 2'd3) state_d = state_q == WB ? FILL : WAIT;
    end else if (state_q == WAIT)
      state_d = INSTALL;
    else if (state_q == INSTALL) begin
      state_d      = DONE;
      lw_en        = 1'b1;
      if (!wr_q) lw_line = fill_line;
      valid_d[idx] = 1'b1;
      dirty_d[idx] = wr_q;
      dout_d       = wr_q ? 16'h0 : fill_line[{wsel, 4'b0} +: 16];
    end else if (state_q == DONE)
      state_d = IDLE;
    done_d  = state_d == DONE;
    stall_d = state_d != IDLE && state_d != DONE;
  end

  // control and output registers; reset drops valid/dirty and aborts any miss in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      dout_q  <= 16'h0;
      done_q  <= 1'b0;
      stall_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      stall_q <= stall_d;
      hit_q   <= hit_d;
    end
    cnt_q   <= cnt_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wr_q    <= wr_d;
    buf_q   <= buf_d;
  end

  // cache arrays and main memory; a word read issued in one cycle is usable two cycles later
  always_ff @(posedge clk) begin
    if (rst && lw_en) begin
      line_mem[idx] <= lw_line;
      tag_mem[idx]  <= req_tag;
    end
    if (rst && state_q == WB) main_mem[{cur_tag, idx, cnt_q}] <= cur_line[{cnt_q, 4'b0} +: 16];
    rd_addr_q <= {addr_q[15:3], cnt_q};
    rd_data_q <= main_mem[rd_addr_q];
  end

`ifdef MEM_SYSTEM_DUMP_EN
  assign unused_bits = Addr[0];
  always @(posedge clk) begin
    if (createdump) begin
      for (int i = 0; i < 32; i++)
        if (valid_q[i])
          for (int w = 0; w < 4; w++)
            $display("dumpfile %04h %04h", {tag_mem[i], i[4:0], w[1:0], 1'b0}, line_mem[i][w*16 +: 16]);
      for (int a = 0; a < 32768; a++)
        if (main_mem[a] != 16'h0) $display("dumpfile %04h %04h", {a[14:0], 1'b0}, main_mem[a]);
    end
  end
`else
  assign unused_bits = Addr[0] ^ createdump;
`endif
endmodule

// File: tb/tb_mem_system.sv
// tb_mem_system: directed and randomized requests checked against a flat word-memory model plus a line-residency model
module tb_mem_system;
  logic        clk = 1'b0, rst = 1'b0, Rd = 1'b0, Wr = 1'b0, createdump = 1'b0;
  logic [15:0] Addr = 16'h0, DataIn = 16'h0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit;
  int          n_chk = 0, n_err = 0;
  logic [15:0] mdl [32768];
  logic [7:0]  m_tag [32];
  logic        m_val [32];
  logic        m_dirty [32];

  mem_system dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .createdump(createdump), .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] dout, output logic hit,
                        output logic stall_ok, output logic stall_done);
    @(negedge clk);
    check("idle_before_req", {30'b0, Done, Stall}, 32'd0);
    rst = 1'b1;
    Rd = rd;
    Wr = wr;
    Addr = a;
    DataIn = d;
    @(posedge clk);
    #1;
    Rd = 1'b0;
    Wr = 1'b0;
    Addr = 16'($urandom);
    DataIn = 16'($urandom);
    lat = 0;
    dout = 16'h0;
    hit = 1'b0;
    stall_ok = 1'b1;
    stall_done = 1'b1;
    while (lat < 30) begin
      @(negedge clk);
      lat++;
      if (Done) begin
        dout = DataOut;
        hit = CacheHit;
        stall_done = Stall;
        break;
      end
      if (!Stall) stall_ok = 1'b0;
    end
  endtask

  task automatic run(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d);
    int          lat, el;
    logic [15:0] dout, ed;
    logic        hit, sok, sdone, eh;
    logic [4:0]  i;
    i  = a[7:3];
    eh = m_val[i] && m_tag[i] == a[15:8];
    el = eh ? 1 : (m_val[i] && m_dirty[i]) ? 11 : 7;
    ed = mdl[a[15:1]];
    do_req(rd, wr, a, d, lat, dout, hit, sok, sdone);
    check("latency", lat, el);
    check("cachehit", {31'b0, hit}, {31'b0, eh});
    check("stall_at_done", {31'b0, sdone}, 32'd0);
    if (el > 1) check("stall_while_busy", {31'b0, sok}, 32'd1);
    if (!wr) check("read_data", {16'b0, dout}, {16'b0, ed});
    if (wr) mdl[a[15:1]] = d;
    m_dirty[i] = eh ? (m_dirty[i] | wr) : wr;
    m_val[i] = 1'b1;
    m_tag[i] = a[15:8];
  endtask

  initial begin
    for (int k = 0; k < 32768; k++) mdl[k] = 16'h0;
    for (int k = 0; k < 32; k++) begin
      m_val[k] = 1'b0;
      m_dirty[k] = 1'b0;
      m_tag[k] = 8'h0;
    end
    repeat (3) @(negedge clk);
    check("reset_outputs", {13'b0, Done, Stall, CacheHit, DataOut}, 32'd0);
    run(1'b1, 1'b0, 16'h0010, 16'h0);
    run(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    run(1'b1, 1'b0, 16'h0010, 16'h0);
    run(1'b1, 1'b0, 16'h1010, 16'h0);
    run(1'b1, 1'b0, 16'h0010, 16'h0);
    run(1'b0, 1'b1, 16'h2046, 16'h1234);
    run(1'b1, 1'b0, 16'h2040, 16'h0);
    run(1'b1, 1'b0, 16'h2046, 16'h0);
    run(1'b1, 1'b1, 16'h2046, 16'h5678);
    run(1'b1, 1'b0, 16'h2047, 16'h0);
    repeat (4) begin
      @(negedge clk);
      Addr = 16'($urandom);
      check("no_request_idle", {30'b0, Done, Stall}, 32'd0);
    end
    for (int n = 0; n < 2000 && n_err < 50; n++) begin
      logic [7:0]  tg;
      logic [4:0]  ix;
      logic [2:0]  lo;
      int          op;
      tg = 8'($urandom_range(0, 3));
      ix = 5'($urandom_range(0, 7));
      lo = 3'($urandom);
      op = $urandom_range(0, 7);
      if (op == 0) begin
        @(negedge clk);
        Addr = 16'($urandom);
        check("no_request_idle", {30'b0, Done, Stall}, 32'd0);
      end
      if (op < 4) run(1'b1, 1'b0, {tg, ix, lo}, 16'h0);
      else if (op < 7) run(1'b0, 1'b1, {tg, ix, lo}, 16'($urandom));
      else run(1'b1, 1'b1, {tg, ix, lo}, 16'($urandom));
    end
    run(1'b0, 1'b1, 16'h3050, 16'hCAFE);
    @(negedge clk);
    Rd = 1'b1;
    Addr = 16'h4050;
    @(posedge clk);
    #1;
    Rd = 1'b0;
    @(negedge clk);
    check("writeback_stall", {31'b0, Stall}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", {13'b0, Done, Stall, CacheHit, DataOut}, 32'd0);
    for (int k = 0; k < 32; k++) begin
      m_val[k] = 1'b0;
      m_dirty[k] = 1'b0;
    end
    run(1'b1, 1'b0, 16'h4050, 16'h0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
